// File: rtl/down_timer_if.sv
// Control/status bundle between a timer and whatever drives it (software
// register block or control FSM).
interface down_timer_if #(
   parameter int WIDTH = 8
) ();
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic             periodic;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;

   modport master (
      output en, load, load_val, start, stop, periodic,
      input  out, busy, done
   );

   modport slave (
      input  en, load, load_val, start, stop, periodic,
      output out, busy, done
   );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting interval timer with one-shot and periodic modes;
// emits a one-cycle done pulse at terminal count.
module down_timer #(
   parameter int WIDTH = 8,
   parameter int MAX   = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   down_timer_if.slave  tif
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] reload_reg, reload_nxt;
   logic [WIDTH-1:0] sat_val, eff_reload;
   logic             done_reg, done_nxt;

   function automatic logic [WIDTH-1:0] sat_reload(input logic [WIDTH-1:0] v);
      return (v > MAX_V) ? MAX_V : v;
   endfunction

   assign sat_val    = sat_reload(tif.load_val);
   // A load in the same cycle as start or a reload is visible immediately.
   assign eff_reload = tif.load ? sat_val : reload_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         reload_reg <= MAX_V;
         done_reg   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         reload_reg <= reload_nxt;
         done_reg   <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      reload_nxt = reload_reg;
      done_nxt   = 1'b0;

      if (tif.stop) begin
         state_nxt = IDLE;
      end else if (tif.start) begin
         if (tif.load)
            reload_nxt = sat_val;
         if (eff_reload == '0) begin
            // Zero-length interval: terminal immediately, never enters RUN.
            done_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end else begin
            cnt_nxt   = eff_reload;
            state_nxt = RUN;
         end
      end else begin
         if (tif.load) begin
            reload_nxt = sat_val;
            if (state == IDLE)
               cnt_nxt = sat_val;
         end
         if (state == RUN && tif.en) begin
            if (cnt > ONE) begin
               cnt_nxt = cnt - ONE;
            end else if (cnt == ONE) begin
               done_nxt = 1'b1;
               // A zero reload cannot sustain a period, so fall back to IDLE.
               if (tif.periodic && eff_reload != '0) begin
                  cnt_nxt = eff_reload;
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
         end
      end
   end

   assign tif.out  = cnt;
   assign tif.busy = (state == RUN);
   assign tif.done = done_reg;

endmodule

// File: tb/tb_down_timer.sv
// Randomized and directed bench for down_timer against an integer-level model
// of the timer's rules.
module tb_down_timer;
   localparam int W   = 9;
   localparam int MAX = 255;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   down_timer_if #(.WIDTH(W)) tif ();

   down_timer #(.WIDTH(W), .MAX(MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tif   (tif)
   );

   always #5 clk = ~clk;

   // Reference model state
   int m_out = 0;
   int m_reload = MAX;
   bit m_run = 0;
   bit m_done = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > MAX) ? MAX : v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int o, r, lv;
      bit run, d;
      if (!rst_n) begin
         m_out <= 0; m_reload <= MAX; m_run <= 0; m_done <= 0;
      end else begin
         o = m_out; r = m_reload; run = m_run; d = 0;
         lv = sat(int'(tif.load_val));
         if (tif.stop) begin
            run = 0;
         end else if (tif.start) begin
            if (tif.load) r = lv;
            if (r == 0) begin d = 1; o = 0; run = 0; end
            else begin o = r; run = 1; end
         end else begin
            if (tif.load) begin
               r = lv;
               if (!run) o = lv;
            end
            if (run && tif.en) begin
               if (o > 1) o = o - 1;
               else if (o == 1) begin
                  d = 1;
                  if (tif.periodic && r > 0) o = r;
                  else begin o = 0; run = 0; end
               end
            end
         end
         m_out <= o; m_reload <= r; m_run <= run; m_done <= d;
      end
   end

   always @(negedge clk) begin
      check("out", int'(tif.out), m_out);
      check("busy", int'(tif.busy), int'(m_run));
      check("done", int'(tif.done), int'(m_done));
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clr();
      tif.en = 0; tif.load = 0; tif.start = 0; tif.stop = 0;
   endtask

   initial begin
      int cyc, dcnt;
      clr(); tif.periodic = 0; tif.load_val = '0;
      step(); step();
      check("rst_out", int'(tif.out), 0);
      check("rst_busy", int'(tif.busy), 0);
      check("rst_done", int'(tif.done), 0);
      rst_n = 1; step();

      // start without load uses the reset reload value
      tif.start = 1; step(); clr();
      check("start_default_out", int'(tif.out), 255);
      check("start_default_busy", int'(tif.busy), 1);

      // asynchronous reset while running at 37
      tif.stop = 1; step(); clr();
      tif.load = 1; tif.load_val = 9'd37; step(); clr();
      tif.start = 1; step(); clr();
      check("run37_out", int'(tif.out), 37);
      @(posedge clk); #2 rst_n = 0; #1;
      check("async_out", int'(tif.out), 0);
      check("async_busy", int'(tif.busy), 0);
      check("async_done", int'(tif.done), 0);
      @(negedge clk); rst_n = 1; step();

      // one-shot of 3 with en held high
      tif.load_val = 9'd3; tif.load = 1; tif.start = 1; tif.en = 1; step();
      tif.load = 0; tif.start = 0;
      check("os_out3", int'(tif.out), 3);
      step(); check("os_out2", int'(tif.out), 2);
      step(); check("os_out1", int'(tif.out), 1); check("os_done_early", int'(tif.done), 0);
      step(); check("os_out0", int'(tif.out), 0); check("os_done", int'(tif.done), 1);
      check("os_busy0", int'(tif.busy), 0);
      step(); check("os_done_clear", int'(tif.done), 0);
      clr();

      // en on alternate cycles: 3 ticks take 5 cycles
      tif.load = 1; tif.start = 1; step(); clr();
      cyc = 0;
      for (int i = 1; i <= 20; i++) begin
         tif.en = i[0]; step();
         if (tif.done) begin cyc = i; break; end
      end
      check("gated_cycles", cyc, 5);
      clr();

      // periodic reload of 4 for 20 cycles
      tif.load_val = 9'd4; tif.load = 1; tif.start = 1; tif.periodic = 1; tif.en = 1; step();
      tif.load = 0; tif.start = 0;
      check("per_out4", int'(tif.out), 4);
      dcnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(); if (tif.done) dcnt++;
      end
      check("per_done_count", dcnt, 5);
      check("per_busy", int'(tif.busy), 1);
      clr(); tif.stop = 1; step(); clr();

      // load while running: reload 5, new value 2 written at out==3
      tif.load_val = 9'd5; tif.load = 1; tif.start = 1; step(); clr();
      tif.en = 1; step(); step();
      check("lr_out3", int'(tif.out), 3);
      tif.load = 1; tif.load_val = 9'd2; step(); tif.load = 0;
      check("lr_out2", int'(tif.out), 2);
      step(); check("lr_out1", int'(tif.out), 1);
      step(); check("lr_reload_out", int'(tif.out), 2); check("lr_done", int'(tif.done), 1);
      step(); step(); check("lr_done2", int'(tif.done), 1);
      clr(); tif.stop = 1; step(); clr(); tif.periodic = 0;

      // stop on the terminal cycle
      tif.load_val = 9'd2; tif.load = 1; tif.start = 1; step(); clr();
      tif.en = 1; step();
      tif.stop = 1; step(); clr();
      check("stopterm_done", int'(tif.done), 0);
      check("stopterm_out", int'(tif.out), 1);
      check("stopterm_busy", int'(tif.busy), 0);
      tif.start = 1; tif.stop = 1; step(); clr();
      check("startstop_busy", int'(tif.busy), 0);

      // zero reload
      tif.load_val = 9'd0; tif.load = 1; tif.start = 1; step(); clr();
      check("zero_done", int'(tif.done), 1);
      check("zero_busy", int'(tif.busy), 0);
      step(); check("zero_done_clear", int'(tif.done), 0);

      // saturation
      tif.load_val = 9'd300; tif.load = 1; step(); clr();
      check("sat_out", int'(tif.out), 255);

      // restart while running at 10
      tif.load_val = 9'd20; tif.load = 1; tif.start = 1; step(); clr();
      tif.en = 1;
      for (int i = 0; i < 10; i++) step();
      check("restart_pre", int'(tif.out), 10);
      tif.en = 0; tif.start = 1; step(); clr();
      check("restart_out", int'(tif.out), 20);
      check("restart_done", int'(tif.done), 0);
      tif.stop = 1; step(); clr();

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         tif.stop     = ($urandom_range(0, 49) == 0);
         tif.start    = ($urandom_range(0, 24) == 0);
         tif.load     = ($urandom_range(0, 14) == 0);
         tif.en       = ($urandom_range(0, 3) != 0);
         tif.periodic = ($urandom_range(0, 1) == 1);
         tif.load_val = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 511))
                                                     : W'($urandom_range(0, 6));
         step();
      end
      clr(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
